// File: rtl/uart_rx_core_if.sv
// Receive-side byte handshake between the UART receiver and its consumer.
interface uart_rx_core_if;
  logic [7:0] Data;
  logic       DataValid;
  logic       DataAck;
  logic       FrameError;
  logic       Overrun;
  logic       Busy;

  // Receiver side: produces bytes and status, takes the acknowledge.
  modport master (
    output Data, DataValid, FrameError, Overrun, Busy,
    input  DataAck
  );

  // Consumer side: takes bytes and status, returns the acknowledge.
  modport slave (
    input  Data, DataValid, FrameError, Overrun, Busy,
    output DataAck
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling from a
// cycle-count bit timer, framing check on the stop bit, and a one-deep
// holding register with valid/ack handshake and overrun pulse.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic           CLK_100MHz,
  input  logic           Reset_n,
  input  logic           Rx,
  uart_rx_core_if.master bus
);

  localparam int unsigned    TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          wait_high_q, wait_high_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic busy, start_ok, data_tick, stop_tick, byte_done, frame_bad;
  logic line_idle;

  assign line_idle = (rx_s_q == IDLE_LEVEL);

  // Two-flop synchroniser; preset to the idle level so reset never fakes a start bit.
  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_s_q    <= IDLE_LEVEL;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: start detect, mid-start confirm, 8 data bits, stop decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!wait_high_q && !line_idle) state_d = S_START;
      S_START: if (timer_q == T_HALF) state_d = line_idle ? S_IDLE : S_DATA;
      S_DATA:  if (timer_q == T_LAST && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (timer_q == T_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the sampling strobes used by the datapath.
  always_comb begin
    busy      = (state_q != S_IDLE);
    start_ok  = (state_q == S_START) && (timer_q == T_HALF) && !line_idle;
    data_tick = (state_q == S_DATA)  && (timer_q == T_LAST);
    stop_tick = (state_q == S_STOP)  && (timer_q == T_LAST);
    byte_done = stop_tick &&  line_idle;
    frame_bad = stop_tick && !line_idle;
  end

  // Datapath next-state: bit timer, shift register, holding register, status pulses.
  always_comb begin
    // Timer restarts on every state change and wraps between data bits.
    if (state_q == S_IDLE || state_d != state_q || timer_q == T_LAST) timer_d = '0;
    else                                                              timer_d = timer_q + TW'(1);

    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (start_ok) bit_idx_d = 3'd0;
    if (data_tick) begin
      shift_d   = {rx_s_q, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    // After a framing error the line must go idle once before a new start is accepted.
    wait_high_d = wait_high_q;
    if (frame_bad)      wait_high_d = 1'b1;
    else if (line_idle) wait_high_d = 1'b0;

    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;
    if (byte_done) begin
      // An ack in the completion cycle frees the slot, so the new byte wins.
      if (!valid_q || bus.DataAck) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.DataAck) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.Data       = data_q;
  assign bus.DataValid  = valid_q;
  assign bus.FrameError = frame_err_q;
  assign bus.Overrun    = overrun_q;
  assign bus.Busy       = busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames from the test plan followed by
// random frames, all checked against a byte-level model of the handshake.
module tb_uart_rx_core;
  localparam int C    = 16;
  localparam int DONE = 3 + C / 2 + 9 * C;   // start edge -> DataValid, in cycles
  localparam int FLEN = 10 * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_core_if bus();

  uart_rx_core #(.CLKS_PER_BIT(C), .IDLE_LEVEL(1'b1)) dut (
    .CLK_100MHz(clk),
    .Reset_n   (rst_n),
    .Rx        (rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Port monitor: counts pulses and logs every byte acceptance.
  int         cyc = 0;
  int         fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, evt_cyc = 0;
  logic       dv_prev = 1'b0, ack_pend = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.DataValid && (!dv_prev || ack_pend)) begin
      got_q.push_back(bus.Data);
      evt_cyc = cyc;
    end
    if (bus.FrameError) fe_cnt++;
    if (bus.Overrun)    ov_cnt++;
    if (bus.Busy)       busy_cnt++;
    dv_prev  = bus.DataValid;
    ack_pend = bus.DataAck;
  end

  // Reference model of the holding register.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_ov = 0;
  int         total = 0, bad = 0;
  int         f_start = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive one 8N1 frame. ack_same raises DataAck in the completion cycle.
  // abort_at >= 0 asserts reset at that cycle of the frame and returns.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_same,
                            input int abort_at);
    logic [9:0] bits;
    bits = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
    for (int i = 0; i < FLEN; i++) begin
      @(posedge clk); #1;
      if (i == 0) f_start = cyc;
      if (i == abort_at) begin
        rst_n = 1'b0;
        rx = 1'b1;
        bus.DataAck = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
        return;
      end
      rx = bits[i / C];
      bus.DataAck = ack_same && (i == DONE - 1);
    end
    rx = 1'b1;
    bus.DataAck = 1'b0;
    if (stop_ok) begin
      if (m_valid && !ack_same) exp_ov++;
      else begin
        m_valid = 1'b1;
        m_data = b;
        exp_q.push_back(b);
      end
    end else begin
      exp_fe++;
      if (ack_same) m_valid = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    bus.DataAck = 1'b1;
    @(posedge clk); #1;
    bus.DataAck = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk); #1;
    chk({tag, ".valid"}, bus.DataValid, m_valid);
    chk({tag, ".data"}, bus.Data, m_data);
    chk({tag, ".fe_cnt"}, fe_cnt, exp_fe);
    chk({tag, ".ov_cnt"}, ov_cnt, exp_ov);
    chk({tag, ".nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int b0;
    int gap;
    int mode;
    bit sok;
    logic [7:0] rb;
    bus.DataAck = 1'b0;

    // Reset values
    idle(3); #1;
    chk("rst.data", bus.Data, 8'h00);
    chk("rst.valid", bus.DataValid, 1'b0);
    chk("rst.fe", bus.FrameError, 1'b0);
    chk("rst.ov", bus.Overrun, 1'b0);
    chk("rst.busy", bus.Busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);

    // Single frame: latency and busy window
    b0 = busy_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    chk("a5.busy_cycles", busy_cnt - b0, C / 2 + 9 * C);
    chk("a5.latency", evt_cyc - f_start, DONE);
    check_state("a5");
    ack_pulse();
    check_state("a5ack");

    // Overrun on an unacknowledged byte
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    check_state("ovr");
    ack_pulse();
    check_state("ovrack");

    // Framing error then a clean frame
    send_frame(8'h81, 1'b0, 1'b0, -1);
    idle(4);
    check_state("ferr");
    send_frame(8'h55, 1'b1, 1'b0, -1);
    check_state("after_ferr");

    // Short low glitch on an idle line
    b0 = busy_cnt;
    @(posedge clk); #1 rx = 1'b0;
    idle(4); #1 rx = 1'b1;
    idle(40);
    @(negedge clk);
    chk("glitch.busy", bus.Busy, 1'b0);
    chk("glitch.busy_cycles", busy_cnt - b0, C / 2);
    check_state("glitch");

    // Back-to-back frames, each acked in the next completion cycle
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    check_state("b2b");

    // Reset during data bit 4
    send_frame(8'hF0, 1'b1, 1'b0, 5 * C + C / 2);
    #1;
    chk("midrst.data", bus.Data, 8'h00);
    chk("midrst.valid", bus.DataValid, 1'b0);
    chk("midrst.busy", bus.Busy, 1'b0);
    chk("midrst.fe", bus.FrameError, 1'b0);
    chk("midrst.ov", bus.Overrun, 1'b0);
    idle(3);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    check_state("after_rst");

    // Random frames: random bytes, occasional bad stop bit, mixed ack timing
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      sok  = ($urandom_range(0, 4) != 0);
      mode = int'($urandom_range(0, 2));
      send_frame(rb, sok, mode == 1, -1);
      if (mode == 2) ack_pulse();
      gap = sok ? int'($urandom_range(0, 3)) : int'($urandom_range(3, 6));
      idle(gap);
    end
    idle(4);
    check_state("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver that deserialises the board's `Rx` line into bytes for the `uart_demo` datapath (LED/seven-segment display, Tx echo path).
- Samples at mid-bit using a clock-cycle bit timer and detects framing errors.
- Holds each received byte in a one-deep output register with a valid/ack handshake and overrun reporting.

Parameters:
- CLKS_PER_BIT, 868, `CLK_100MHz` cycles per bit (100 MHz / 115200 baud); legal range 4..65535.
- IDLE_LEVEL, 1'b1, line level when idle (start bit = ~IDLE_LEVEL).

Ports:
- CLK_100MHz  input  1  system clock, all logic on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Rx  input  1  asynchronous serial line, idle high.
- Data  output  8  last accepted byte, LSB received first.
- DataValid  output  1  level; high while `Data` holds an unacknowledged byte.
- DataAck  input  1  consumer acknowledge; clears `DataValid` on the cycle it is sampled high.
- FrameError  output  1  one-cycle pulse when the stop bit samples low.
- Overrun  output  1  one-cycle pulse when a byte completes while `DataValid` is still high and `DataAck` is low.
- Busy  output  1  high from start-bit detection until the stop-bit decision.

Behaviour:
- Reset (asynchronous, `Reset_n` = 0):
  - Outputs: `Data` = 8'h00, `DataValid` = 0, `FrameError` = 0, `Overrun` = 0, `Busy` = 0.
  - Internal state: FSM = IDLE; synchroniser flops preset to IDLE_LEVEL; bit timer = 0; bit index = 0.
- Input synchronisation: `Rx` passes through a 2-flop synchroniser; only the synchronised value `rx_s` is used. This gives 2 cycles of input latency.
- Bit timer: counts 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). It restarts on every state transition.
- FSM states:
  - IDLE: `Busy` = 0. On `rx_s` = ~IDLE_LEVEL, go to START with timer = 0.
  - START: at timer = (CLKS_PER_BIT/2)-1 (integer division), sample `rx_s`.
    - If still low: go to DATA, timer = 0, bit index = 0.
    - If high (glitch): return to IDLE with no outputs.
  - DATA: at timer = CLKS_PER_BIT-1, shift `rx_s` into the MSB of the shift register (LSB-first line order) and increment the bit index. After index 7, go to STOP.
  - STOP: at timer = CLKS_PER_BIT-1, sample `rx_s`.
    - High: byte complete, apply the holding rules below.
    - Low: pulse `FrameError`; the byte is discarded and `DataValid`/`Data` are unchanged.
    - In both cases go to IDLE.
    - In the low case, stay in IDLE until `rx_s` has been seen high for at least one cycle (break/stuck-low must not retrigger).
- Holding register on byte complete:
  - `DataValid` = 0, or `DataAck` = 1 in the same cycle: load `Data`, set `DataValid` = 1, no overrun.
  - `DataValid` = 1 and `DataAck` = 0: keep the old `Data`, pulse `Overrun`, drop the new byte.
- `DataAck` with `DataValid` = 0 has no effect.
- `DataAck` and completion in the same cycle: the new byte wins and `DataValid` stays 1.
- `Busy` is high in START, DATA and STOP.
- Latency: `DataValid` rises one cycle after the mid-stop sample, about 9.5 bit times plus 3 cycles after the start edge on `Rx`.
- Back-to-back frames: a start edge arriving immediately after the stop sample is detected from IDLE without loss.
- Reset mid-frame: everything returns to reset values at once, and the partial byte is lost.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 8N1 -> `Data`=8'hA5, `DataValid`=1 about 155 cycles after the start edge; `FrameError`=0, `Overrun`=0; `Busy` high for the frame.
- Send 8'h3C and leave it unacked, then send 8'hC3 -> `Overrun` pulses once, `Data` stays 8'h3C; assert `DataAck` -> `DataValid`=0.
- Send 8'h81 with the stop bit forced low for 1 bit, then idle -> `FrameError` one-cycle pulse, `DataValid` unchanged, FSM back in IDLE, next frame 8'h55 received correctly.
- Low glitch of 4 cycles on an idle line -> no `Busy` after the START check, no outputs, FSM in IDLE.
- Three back-to-back frames 8'h00, 8'hFF, 8'h5A, each acked on the cycle `DataValid` rises (`DataAck` coinciding with the next completion) -> all three bytes captured in order, no `Overrun`.
- Deassert `Reset_n` during bit 4 of 8'hF0 -> all outputs 0 immediately; after release the next frame 8'h12 is received correctly.
